// File: rtl/io_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// register-window offsets and window size.
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OFF_PENDING = 4'h0;
    localparam logic [3:0] OFF_MASK    = 4'h4;
    localparam logic [3:0] OFF_ID      = 4'h8;
    localparam logic [3:0] OFF_RSVD    = 4'hC;

    localparam int unsigned REG_WIN_BYTES = 16;

endpackage

// File: rtl/io_intr_ctrl_if.sv
// CPU bus and interrupt handshake bundle for io_intr_ctrl.
// The tri-state read bus IO_D_Out is a direct port on the controller.
interface io_intr_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
);
    logic [ADDR_W-1:0] Addr;
    logic [31:0]       D_In;
    logic              IO_wr;
    logic              IO_rd;
    logic [NUM_CH-1:0] intr;
    logic              intr_req;
    logic              intr_ack;
    logic [ID_W-1:0]   intr_id;

    modport master (
        output Addr, D_In, IO_wr, IO_rd, intr, intr_ack,
        input  intr_req, intr_id
    );

    modport slave (
        input  Addr, D_In, IO_wr, IO_rd, intr, intr_ack,
        output intr_req, intr_id
    );
endinterface

// File: rtl/io_prio_enc.sv
// Lowest-index-first priority encoder over the active channel vector.
module io_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    output logic [ID_W-1:0]   id_o,
    output logic              valid_o
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        id_o    = '0;
        valid_o = 1'b0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (req_i[i-1]) begin
                id_o    = ID_W'(i - 1);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_intr_ctrl.sv
// Memory-mapped IO block: big-endian byte memory plus a 16-byte register
// window (PENDING/MASK/ID) in front of an edge-triggered interrupt
// controller with a three-state request/ack FSM.
module io_intr_ctrl
    import io_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic          sys_clk,
    input  logic          reset_n,
    io_intr_ctrl_if.slave bus,
    output logic [31:0]   IO_D_Out
);

    localparam logic [ADDR_W-1:0] REG_BASE = ADDR_W'((2 ** ADDR_W) - REG_WIN_BYTES);

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] base;
    logic [3:0]        reg_off;
    logic              reg_hit;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       mem_rdata;
    logic [31:0]       rd_data;

    logic [NUM_CH-1:0] intr_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [NUM_CH-1:0] edge_set;
    logic [NUM_CH-1:0] w1c_clr;
    logic [NUM_CH-1:0] ack_clr;
    logic [NUM_CH-1:0] active;
    logic [ID_W-1:0]   prio_id;
    logic              prio_vld;

    // Address low bits are masked off to give word-aligned access.
    assign base    = bus.Addr & ~ADDR_W'(3);
    assign reg_off = base[3:0];
    assign reg_hit = (base[ADDR_W-1:4] == REG_BASE[ADDR_W-1:4]);
    assign wr_en   = bus.IO_wr & ~bus.IO_rd;
    assign rd_en   = bus.IO_rd & ~bus.IO_wr;

    assign mem_rdata = {mem[base], mem[base | ADDR_W'(1)],
                        mem[base | ADDR_W'(2)], mem[base | ADDR_W'(3)]};

    // Big-endian word write into byte memory; contents survive reset.
    always_ff @(posedge sys_clk) begin
        if (wr_en && !reg_hit) begin
            mem[base]               <= bus.D_In[31:24];
            mem[base | ADDR_W'(1)]  <= bus.D_In[23:16];
            mem[base | ADDR_W'(2)]  <= bus.D_In[15:8];
            mem[base | ADDR_W'(3)]  <= bus.D_In[7:0];
        end
    end

    assign edge_set = bus.intr & ~intr_q;
    assign active   = pending_q & mask_q;

    io_prio_enc #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_prio (
        .req_i   (active),
        .id_o    (prio_id),
        .valid_o (prio_vld)
    );

    // Register writes: W1C on PENDING (a new edge wins), plain write on MASK.
    always_comb begin
        w1c_clr = '0;
        mask_d  = mask_q;
        if (wr_en && reg_hit && (reg_off == OFF_PENDING)) begin
            w1c_clr = bus.D_In[NUM_CH-1:0];
        end
        if (wr_en && reg_hit && (reg_off == OFF_MASK)) begin
            mask_d = bus.D_In[NUM_CH-1:0];
        end
        pending_d = (pending_q & ~w1c_clr & ~ack_clr) | edge_set;
    end

    // Request FSM next state: only an ack leaves REQ, so masking or clearing
    // the serviced channel cannot withdraw a request already raised.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (prio_vld) begin
                    id_d    = prio_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.intr_ack) begin
                    ack_clr = NUM_CH'(1) << id_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                id_d    = '0;
                state_d = ST_IDLE;
            end
            default: begin
                id_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers with asynchronous clear.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            intr_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= ST_IDLE;
            id_q      <= '0;
        end else begin
            intr_q    <= bus.intr;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            id_q      <= id_d;
        end
    end

    assign bus.intr_req = (state_q == ST_REQ);
    assign bus.intr_id  = (state_q == ST_REQ) ? id_q : '0;

    // Read mux: register window in front of memory, unused bits read zero.
    always_comb begin
        rd_data = mem_rdata;
        if (reg_hit) begin
            unique case (reg_off)
                OFF_PENDING: rd_data = 32'(pending_q);
                OFF_MASK:    rd_data = 32'(mask_q);
                OFF_ID:      rd_data = {bus.intr_req, 15'b0, 16'(bus.intr_id)};
                OFF_RSVD:    rd_data = '0;
                default:     rd_data = '0;
            endcase
        end
    end

    assign IO_D_Out = rd_en ? rd_data : 'z;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Scoreboard bench for io_intr_ctrl: stimulus queues expected read data and
// expected request IDs; a monitor compares them as the DUT presents them.
module tb_io_intr_ctrl;

    localparam int ADDR_W = 12;
    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;

    localparam logic [11:0] A_PEND = 12'hFF0;
    localparam logic [11:0] A_MASK = 12'hFF4;
    localparam logic [11:0] A_ID   = 12'hFF8;
    localparam logic [11:0] A_RSVD = 12'hFFC;
    localparam logic [31:0] ALL    = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] msk;
        string       name;
    } rd_exp_t;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] io_d_out;

    rd_exp_t     rd_q[$];
    int unsigned req_q[$];
    int          errors    = 0;
    int          checks    = 0;
    int          timeouts  = 0;
    bit          finish_req = 1'b0;
    bit          req_prev  = 1'b0;

    io_intr_ctrl_if #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .ID_W(ID_W)) bus ();

    io_intr_ctrl #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .IO_D_Out (io_d_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.Addr  = a;
        bus.D_In  = d;
        bus.IO_wr = 1'b1;
        tick();
        bus.IO_wr = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e,
                      input logic [31:0] m, input string n);
        rd_exp_t x;
        x.exp  = e;
        x.msk  = m;
        x.name = n;
        rd_q.push_back(x);
        bus.Addr  = a;
        bus.IO_rd = 1'b1;
        tick();
        bus.IO_rd = 1'b0;
    endtask

    task automatic ack();
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        bus.intr = v;
        tick();
        bus.intr = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.intr_req && n < 20) begin
            tick();
            n++;
        end
        if (!bus.intr_req) timeouts++;
    endtask

    // Monitor: checks every read the bench issues and every new request.
    initial begin
        rd_exp_t     e;
        int unsigned eid;
        forever begin
            @(negedge sys_clk);
            if (bus.IO_rd && !bus.IO_wr) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: addr=%h got=%h required none", bus.Addr, io_d_out);
                end else begin
                    e = rd_q.pop_front();
                    if ((io_d_out & e.msk) !== e.exp) begin
                        errors++;
                        $display("FAIL %s: got=%h required=%h", e.name, io_d_out & e.msk, e.exp);
                    end
                end
            end
            if (bus.intr_req && !req_prev) begin
                checks++;
                if (req_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: id=%0d required no request", bus.intr_id);
                end else begin
                    eid = req_q.pop_front();
                    if (32'(bus.intr_id) != eid) begin
                        errors++;
                        $display("FAIL req_id: got=%0d required=%0d", bus.intr_id, eid);
                    end
                end
            end
            req_prev = bus.intr_req;
            if (finish_req) begin
                checks++;
                if (rd_q.size() != 0 || req_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: reads=%0d reqs=%0d required 0 and 0", rd_q.size(), req_q.size());
                end
                checks++;
                if (timeouts != 0) begin
                    errors++;
                    $display("FAIL req_timeout: got=%0d required=0", timeouts);
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: finish_req=%0b required 1", finish_req);
        $fatal(1, "bench did not complete");
    end

    initial begin
        bus.Addr     = '0;
        bus.D_In     = '0;
        bus.IO_wr    = 1'b0;
        bus.IO_rd    = 1'b0;
        bus.intr     = '0;
        bus.intr_ack = 1'b0;
        reset_n      = 1'b0;
        tick();
        rd(A_PEND, 32'h0, ALL, "rst_pend");
        rd(A_MASK, 32'h0, ALL, "rst_mask");
        rd(A_ID,   32'h0, ALL, "rst_id");
        reset_n = 1'b1;
        tick();

        // Single channel, latency and ack
        wr(A_MASK, 32'hF);
        req_q.push_back(2);
        pulse(4'b0100);
        rd(A_ID,   32'h0,         ALL, "lat_id_early");
        rd(A_PEND, 32'h4,         ALL, "lat_pend");
        rd(A_ID,   32'h8000_0002, ALL, "lat_id_req");
        ack();
        rd(A_ID,   32'h0,         ALL, "ack_gap");
        rd(A_PEND, 32'h0,         ALL, "ack_clr");

        // Memory and register window
        wr(12'h010, 32'hDEAD_BEEF);
        rd(12'h012, 32'hDEAD_BEEF, ALL, "mem_word");
        rd(12'h010, 32'hDE00_0000, 32'hFF00_0000, "mem_msb");
        wr(12'h014, 32'h0102_0304);
        rd(12'h017, 32'h0102_0304, ALL, "mem_word2");
        bus.Addr  = 12'h010;
        bus.D_In  = 32'h1234_5678;
        bus.IO_wr = 1'b1;
        bus.IO_rd = 1'b1;
        tick();
        bus.IO_wr = 1'b0;
        bus.IO_rd = 1'b0;
        rd(12'h010, 32'hDEAD_BEEF, ALL, "wr_rd_noop");
        wr(A_ID, ALL);
        rd(A_ID, 32'h0, ALL, "id_readonly");
        wr(A_RSVD, ALL);
        rd(A_RSVD, 32'h0, ALL, "rsvd_zero");
        wr(A_MASK, ALL);
        rd(A_MASK, 32'hF, ALL, "mask_upper");

        // Two channels at once: lowest first, then the other after the gap
        req_q.push_back(1);
        req_q.push_back(3);
        pulse(4'b1010);
        wait_req();
        rd(A_ID, 32'h8000_0001, ALL, "prio_first");
        ack();
        rd(A_ID, 32'h0, ALL, "prio_gap");
        wait_req();
        rd(A_ID, 32'h8000_0003, ALL, "prio_second");
        ack();
        rd(A_PEND, 32'h0, ALL, "prio_clr");

        // Masked channel, held level, unmask latency, hold in REQ
        wr(A_MASK, 32'h0);
        pulse(4'b0001);
        rd(A_PEND, 32'h1, ALL, "masked_pend");
        rd(A_ID,   32'h0, ALL, "masked_noreq");
        bus.intr = 4'b1000;
        tick();
        tick();
        wr(A_PEND, 32'h8);
        rd(A_PEND, 32'h1, ALL, "level_no_reset");
        bus.intr = '0;
        req_q.push_back(0);
        wr(A_MASK, 32'h1);
        rd(A_ID, 32'h0,         ALL, "unmask_lat");
        rd(A_ID, 32'h8000_0000, ALL, "unmask_req");
        wr(A_MASK, 32'h0);
        wr(A_PEND, 32'h1);
        rd(A_ID,   32'h8000_0000, ALL, "req_hold");
        rd(A_PEND, 32'h0,         ALL, "w1c_in_req");
        ack();
        tick();
        tick();
        rd(A_ID, 32'h0, ALL, "no_rereq");
        wr(A_MASK, 32'hF);

        // New edge on the serviced channel in the same cycle as ack
        req_q.push_back(2);
        req_q.push_back(2);
        pulse(4'b0100);
        wait_req();
        bus.intr     = 4'b0100;
        bus.intr_ack = 1'b1;
        tick();
        bus.intr     = '0;
        bus.intr_ack = 1'b0;
        rd(A_PEND, 32'h4, ALL, "edge_beats_ack");
        wait_req();
        rd(A_ID, 32'h8000_0002, ALL, "second_req");
        ack();
        rd(A_PEND, 32'h0, ALL, "second_clr");

        // Asynchronous reset during an active request
        req_q.push_back(1);
        pulse(4'b0010);
        wait_req();
        rd(A_ID, 32'h8000_0001, ALL, "pre_rst_req");
        #2;
        reset_n = 1'b0;
        rd(A_ID,   32'h0, ALL, "rst_async_id");
        rd(A_PEND, 32'h0, ALL, "rst_async_pend");
        rd(A_MASK, 32'h0, ALL, "rst_async_mask");
        reset_n = 1'b1;
        tick();
        rd(12'h010, 32'hDEAD_BEEF, ALL, "mem_kept");
        rd(A_ID,    32'h0,         ALL, "post_rst_idle");

        finish_req = 1'b1;
    end

endmodule

// File: doc/io_intr_ctrl.md
IO_INTR_CTRL -- requirements
Module: io_intr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, is the byte-address width; memory depth SHALL be 2**ADDR_W bytes.
REQ-002 Parameter NUM_CH, default 4 (range 1..16), is the number of interrupt source channels.
REQ-003 Parameter ID_W, default 2, is the channel-ID width and SHALL equal max(1, clog2(NUM_CH)).
REQ-004 sys_clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 Addr  in  ADDR_W  byte address; Addr[1:0] SHALL be ignored, giving word-aligned access.
REQ-007 D_In  in  32  write data.
REQ-008 IO_wr  in  1  synchronous write strobe.
REQ-009 IO_rd  in  1  asynchronous read enable.
REQ-010 IO_D_Out  out  32  read data; SHALL be 32'bz unless IO_rd=1 and IO_wr=0.
REQ-011 intr  in  NUM_CH  per-channel interrupt sources, synchronous to sys_clk.
REQ-012 intr_req  out  1  registered interrupt request to the CPU.
REQ-013 intr_ack  in  1  CPU interrupt acknowledge.
REQ-014 intr_id  out  ID_W  channel being requested; valid while intr_req=1, 0 otherwise.

Function
REQ-015 Memory SHALL be byte-addressed and big-endian: word = {M[a],M[a+1],M[a+2],M[a+3]}, with a = {Addr[ADDR_W-1:2],2'b00}.
REQ-016 A write with IO_wr=1 and IO_rd=0 SHALL update all four bytes at the rising edge; IO_wr=IO_rd=1 SHALL be a no-op with IO_D_Out=z.
REQ-017 The top 16 bytes are the register window (REG_BASE = 2**ADDR_W-16); accesses there SHALL hit registers, not memory.
REQ-018 Offset 0x0 PENDING[NUM_CH-1:0]: read returns the pending bits; a write clears each bit where D_In=1 (W1C).
REQ-019 Offset 0x4 MASK[NUM_CH-1:0]: read/write; bit=1 enables the channel.
REQ-020 Offset 0x8 ID: read returns {intr_req, 15'b0, 16-bit zero-extended intr_id}; writes SHALL be ignored.
REQ-021 Offset 0xC SHALL read 0; writes SHALL be ignored. Unused upper register bits SHALL read 0.
REQ-022 Edge detect: a 0->1 transition on intr[i], sampled against a registered copy, sets PENDING[i] at that edge; a level held high SHALL NOT re-set the bit.
REQ-023 Same-edge conflict on one PENDING bit: setting by an edge SHALL win over clearing by W1C or by ack.
REQ-024 FSM state IDLE: intr_req=0. When (PENDING & MASK) != 0, the FSM SHALL latch the lowest-index such channel into intr_id and go to REQ.
REQ-025 FSM state REQ: intr_req=1 and intr_id is held. On intr_ack=1 the FSM SHALL clear PENDING[intr_id] and go to DONE.
REQ-026 FSM state DONE: intr_req=0 for exactly one cycle, then the FSM SHALL go to IDLE. This state is the mandatory deassert gap between requests.
REQ-027 Latency: an intr edge sampled at edge k sets PENDING after edge k; intr_req=1 after edge k+1 (FSM idle, channel unmasked).
REQ-028 Masking or W1C-clearing the serviced channel while in REQ SHALL NOT withdraw intr_req; only intr_ack ends REQ.
REQ-029 intr_ack seen in IDLE or DONE SHALL be ignored.

Reset
REQ-030 When reset_n=0, the block SHALL immediately, without waiting for a clock edge, set PENDING=0, MASK=0, the edge-sample register=0, FSM=IDLE, intr_req=0 and intr_id=0.
REQ-031 Memory contents SHALL NOT be reset. Reset asserted mid-request SHALL drop intr_req at once and lose all pending interrupts.

Structure
REQ-032 A shared package io_pkg SHALL hold the FSM state encoding (IDLE, REQ, DONE), the register offsets (0x0/0x4/0x8/0xC) and the 16-byte window size.
REQ-033 The lowest-index-first priority encoder SHALL be a sub-module named io_prio_enc, parametrised by NUM_CH.

Verification
REQ-034 Reset, MASK=4'hF, pulse intr=4'b0100 -> PENDING=4'b0100 after 1 edge; intr_req=1 and intr_id=2 after 2 edges; intr_ack -> PENDING=0, intr_req low for ≥1 cycle.
REQ-035 Write 32'hDEADBEEF to Addr 12'h010, read Addr 12'h012 -> IO_D_Out=32'hDEADBEEF; a byte read at 12'h010 returns 8'hDE in the MSB.
REQ-036 MASK=4'hF, intr edges on channels 3 and 1 in the same cycle -> intr_id=1 first; after ack and the DONE gap, intr_id=3.
REQ-037 MASK=0, intr edge on channel 0 -> PENDING=1 and intr_req stays 0; write MASK=1 -> intr_req=1 two edges later.
REQ-038 In REQ on channel 2, a new channel-2 edge arrives on the same edge as intr_ack -> PENDING[2] stays 1 and a second request is issued after DONE.
REQ-039 Assert reset_n=0 while intr_req=1 -> intr_req=0 immediately, PENDING=0 and MASK=0; memory word at 12'h010 is unchanged.
